// File: rtl/anim_pkg.sv
// Shared constants and types for the seven-segment animation controller.
package anim_pkg;

  localparam int unsigned NUM_BTN     = 4;
  localparam int unsigned BTN_INC_ANI = 0;
  localparam int unsigned BTN_DEC_ANI = 1;
  localparam int unsigned BTN_INC_SPD = 2;
  localparam int unsigned BTN_DEC_SPD = 3;

  localparam int unsigned SPEED_W = 3;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } run_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, counting debouncer and rising-edge press pulse.
// Presses are only reported once the input has been seen released after reset.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      arm_cnt_q    <= '0;
      armed_q      <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_in;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      arm_cnt_q    <= arm_cnt_d;
      armed_q      <= armed_d;
      press_q      <= press_d;
    end
  end

  always_comb begin
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;

    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Arm only after a debounce-length run of released input, so a button
    // held through reset cannot fire until it is released and pressed again.
    if (!armed_q) begin
      if (sync2_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        armed_d   = 1'b1;
        arm_cnt_d = '0;
      end else begin
        arm_cnt_d = arm_cnt_q + CW'(1);
      end
    end

    press_d = armed_q & stable_q & ~stable_dly_q;
  end

  assign press = press_q;

endmodule

// File: rtl/anim_ctrl.sv
// Animation controller: button conditioning, animation/speed selection,
// step timer and frame counter for the seven-segment pattern generator.
module anim_ctrl
  import anim_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter int unsigned BASE_TICKS      = 1000,
  parameter int unsigned NUM_ANI         = 8,
  parameter int unsigned FRAME_LEN       = 16,
  parameter int unsigned SPEED_RESET     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [NUM_BTN-1:0]           btn_in,
  output logic [$clog2(NUM_ANI)-1:0]   ani_sel,
  output logic [SPEED_W-1:0]           speed,
  output logic                         step,
  output logic [$clog2(FRAME_LEN)-1:0] frame,
  output logic                         ani_changed
);

  localparam int unsigned AW = $clog2(NUM_ANI);
  localparam int unsigned FW = $clog2(FRAME_LEN);
  localparam int unsigned TW = $clog2(BASE_TICKS * 128);

  logic [NUM_BTN-1:0] press;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn_in(btn_in[i]),
      .press (press[i])
    );
  end

  // Run/hold state machine
  run_state_e state_q, state_d;
  logic       run_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ena) state_d = RUN;
    else     state_d = HOLD;
  end

  always_comb begin
    run_c = 1'b0;
    if (state_q == RUN) run_c = 1'b1;
  end

  // Selection, speed, timer and frame datapath
  logic [AW-1:0]      ani_sel_q, ani_sel_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               step_q, step_d;
  logic               ani_changed_q, ani_changed_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ani_sel_q     <= '0;
      speed_q       <= SPEED_W'(SPEED_RESET);
      frame_q       <= '0;
      timer_q       <= '0;
      step_q        <= 1'b0;
      ani_changed_q <= 1'b0;
    end else begin
      ani_sel_q     <= ani_sel_d;
      speed_q       <= speed_d;
      frame_q       <= frame_d;
      timer_q       <= timer_d;
      step_q        <= step_d;
      ani_changed_q <= ani_changed_d;
    end
  end

  logic          ani_inc_c, ani_dec_c, spd_inc_c, spd_dec_c;
  logic [TW-1:0] period_m1_c;

  always_comb begin
    ani_inc_c   = run_c & press[BTN_INC_ANI] & ~press[BTN_DEC_ANI];
    ani_dec_c   = run_c & press[BTN_DEC_ANI] & ~press[BTN_INC_ANI];
    spd_inc_c   = run_c & press[BTN_INC_SPD] & ~press[BTN_DEC_SPD];
    spd_dec_c   = run_c & press[BTN_DEC_SPD] & ~press[BTN_INC_SPD];
    period_m1_c = (TW'(BASE_TICKS) << (SPEED_MAX - speed_q)) - TW'(1);

    ani_sel_d     = ani_sel_q;
    speed_d       = speed_q;
    frame_d       = frame_q;
    timer_d       = timer_q;
    step_d        = 1'b0;
    ani_changed_d = 1'b0;

    if (run_c) begin
      if (timer_q == period_m1_c) begin
        timer_d = '0;
        step_d  = 1'b1;
        frame_d = (frame_q == FW'(FRAME_LEN - 1)) ? '0 : frame_q + FW'(1);
      end else begin
        timer_d = timer_q + TW'(1);
      end

      if (spd_inc_c && speed_q != SPEED_MAX) begin
        speed_d = speed_q + SPEED_W'(1);
        timer_d = '0;
      end else if (spd_dec_c && speed_q != '0) begin
        speed_d = speed_q - SPEED_W'(1);
        timer_d = '0;
      end

      // An animation change overrides any simultaneous timer wrap
      if (ani_inc_c || ani_dec_c) begin
        if (ani_inc_c) begin
          ani_sel_d = (ani_sel_q == AW'(NUM_ANI - 1)) ? '0 : ani_sel_q + AW'(1);
        end else begin
          ani_sel_d = (ani_sel_q == '0) ? AW'(NUM_ANI - 1) : ani_sel_q - AW'(1);
        end
        frame_d       = '0;
        timer_d       = '0;
        step_d        = 1'b0;
        ani_changed_d = 1'b1;
      end
    end
  end

  assign ani_sel     = ani_sel_q;
  assign speed       = speed_q;
  assign frame       = frame_q;
  assign step        = step_q;
  assign ani_changed = ani_changed_q;

endmodule
